bit_count_seq: RTL and testbench
================================

// Module: bit_count_seq
// PURPOSE
//   Sequential, parametrised zero/one bit counter with valid/ready handshakes on both sides.
//   Generalises the fixed 8-bit combinational zero-count to any DATA_W.
//   Processes CHUNK_W bits per cycle, so wide words are counted without a wide adder tree.
//   Sits between a producer of status/mask words and consumers needing population counts
//   (e.g. free-slot counters, error-bit tallies).
// PARAMETERS
//   DATA_W   32  width of input word; must be >= 1
//   CHUNK_W   8  bits counted per cycle; DATA_W % CHUNK_W == 0, CHUNK_W <= DATA_W
//   (local) NCHUNK = DATA_W/CHUNK_W
//   (local) CNT_W  = $clog2(DATA_W+1)
//   (local) IDX_W  = max(1,$clog2(NCHUNK))
// PORTS
//   CLK        in   1        clock, all logic on rising edge
//   RST        in   1        synchronous reset, active-low
//   in_valid   in   1        in_data/in_mode valid
//   in_ready   out  1        block can accept a word
//   in_data    in   DATA_W   word to count
//   in_mode    in   1        0 = count zero bits, 1 = count one bits
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   out_count  out  CNT_W    number of matching bits, 0..DATA_W
//   out_all    out  1        1 when out_count == DATA_W
//   out_none   out  1        1 when out_count == 0
// BEHAVIOUR
//   Reset (RST==0 at a rising edge): state=IDLE, in_ready=1, out_valid=0, out_count=0,
//     out_all=0, out_none=0, chunk index=0, latched data cleared. Takes priority over everything.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1; on in_valid&&in_ready, latch in_data and in_mode, clear accumulator,
//     index=0, go RUN.
//   RUN: in_ready=0; each cycle add the count of matching bits in chunk[index]
//     (bits index*CHUNK_W .. +CHUNK_W-1) to the accumulator; index+1.
//     After chunk NCHUNK-1, register out_count/out_all/out_none and go DONE.
//   DONE: out_valid=1, outputs stable, in_ready=0; on out_valid&&out_ready go IDLE;
//     out_valid drops the next cycle.
//   Latency: out_valid rises exactly NCHUNK cycles after the input-handshake edge.
//   Throughput: one word per NCHUNK+2 cycles; no overlap of input and output handshakes.
//   Width rules:
//     - accumulator is CNT_W bits and never wraps (max DATA_W);
//     - index is IDX_W bits and the terminal test is index==NCHUNK-1, never index overflow;
//     - no loop or counter whose width cannot reach its terminal value.
//   in_data/in_mode changes while not in IDLE are ignored; in_valid may drop without effect.
//   out_ready outside DONE is ignored; out_* hold their last value until the next DONE.
//   Reset mid-RUN or mid-DONE aborts: partial result discarded, no out_valid pulse.
//   Bits of in_data are never X-propagated: X on in_data is a bench error, not handled.
// TESTING (defaults DATA_W=32, CHUNK_W=8 unless stated)
//   1. in_data=32'h0000_0000, mode=0 -> out_count=32, out_all=1, out_none=0;
//      out_valid exactly 4 cycles after accept.
//   2. in_data=32'hF0F0_F0F1, mode=1 -> out_count=17; same word mode=0 -> out_count=15.
//   3. Result pending, out_ready=0 for 5 cycles -> out_valid/out_count stable, in_ready=0;
//      out_ready=1 -> in_ready=1 next cycle.
//   4. RST low during RUN (2nd chunk) -> next cycle IDLE, out_valid=0, outputs 0;
//      next word 32'hFFFF_FFFF mode=1 -> 32.
//   5. DATA_W=8, CHUNK_W=8: in_data=8'b1010_0110 mode=0 -> out_count=4, latency 1 cycle;
//      8'hFF mode=0 -> out_none=1.
//   6. Back-to-back: in_valid and out_ready held high, 10 random words
//      -> each count matches the reference model, one result per 6 cycles.

Source files
------------

// File: rtl/bit_count_seq.sv
// Sequential population counter: counts zero or one bits of a DATA_W word,
// CHUNK_W bits per cycle, with valid/ready handshakes on input and result.
module bit_count_seq #(
   parameter int DATA_W  = 32,
   parameter int CHUNK_W = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [DATA_W-1:0]            in_data_i,
   input  logic                         in_mode_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [$clog2(DATA_W+1)-1:0]  out_count_o,
   output logic                         out_all_o,
   output logic                         out_none_o
);

   localparam int NCHUNK = DATA_W / CHUNK_W;
   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                mode_q, mode_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                all_q, all_d;
   logic                none_q, none_d;

   logic [DATA_W-1:0]   shifted;
   logic [CHUNK_W-1:0]  match;
   logic [CNT_W-1:0]    chunk_cnt;
   logic [CNT_W-1:0]    acc_sum;
   logic                last_chunk;

   // Select the current chunk and count the bits that agree with the latched mode
   // (mode 0 inverts the chunk so zeros are counted as ones).
   always_comb begin
      shifted   = data_q >> (idx_q * CHUNK_W);
      match     = shifted[CHUNK_W-1:0] ^ {CHUNK_W{~mode_q}};
      chunk_cnt = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
         chunk_cnt = chunk_cnt + CNT_W'(match[i]);
      end
      acc_sum    = acc_q + chunk_cnt;
      last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      count_d = count_q;
      all_d   = all_q;
      none_d  = none_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               data_d  = in_data_i;
               mode_d  = in_mode_i;
               acc_d   = '0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_sum;
            // Index resets on the final chunk rather than wrapping, so it never
            // needs to represent NCHUNK.
            if (last_chunk) begin
               idx_d   = '0;
               count_d = acc_sum;
               all_d   = (acc_sum == CNT_W'(DATA_W));
               none_d  = (acc_sum == '0);
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         data_q  <= '0;
         mode_q  <= 1'b0;
         idx_q   <= '0;
         acc_q   <= '0;
         count_q <= '0;
         all_q   <= 1'b0;
         none_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         all_q   <= all_d;
         none_q  <= none_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign out_count_o = count_q;
   assign out_all_o   = all_q;
   assign out_none_o  = none_q;

endmodule

// File: tb/tb_bit_count_seq.sv
// Directed and randomized checks of bit_count_seq (32/8 and 8/8 configurations)
// against a popcount reference model.
module tb_bit_count_seq;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_all, out_none;
   logic [31:0] in_data;
   logic [5:0]  out_count;

   logic        in_valid8, in_ready8, in_mode8, out_valid8, out_ready8, out_all8, out_none8;
   logic [7:0]  in_data8;
   logic [3:0]  out_count8;

   int testCount = 0;
   int failCount = 0;

   bit_count_seq #(.DATA_W(32), .CHUNK_W(8)) dut32 (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_mode_i(in_mode),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_count_o(out_count),
      .out_all_o(out_all), .out_none_o(out_none)
   );

   bit_count_seq #(.DATA_W(8), .CHUNK_W(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid8), .in_ready_o(in_ready8), .in_data_i(in_data8), .in_mode_i(in_mode8),
      .out_valid_o(out_valid8), .out_ready_i(out_ready8), .out_count_o(out_count8),
      .out_all_o(out_all8), .out_none_o(out_none8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int refCount(input logic [31:0] d, input logic m, input int w);
      logic [31:0] masked;
      masked = (w >= 32) ? d : (d & ((32'd1 << w) - 32'd1));
      return m ? $countones(masked) : (w - $countones(masked));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hand one word to the 32-bit instance, then scramble the inputs to show they are ignored.
   task automatic applyStimulus(input logic [31:0] d, input logic m);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      tick();
      in_valid = 1'b0;
      in_data  = $urandom;
      in_mode  = 1'($urandom);
   endtask

   task automatic waitResult(input string tag, input logic [31:0] d, input logic m);
      int lat;
      int exp;
      lat = 0;
      exp = refCount(d, m, 32);
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
      checkOutput({tag, "_count"}, 32'(out_count), 32'(exp));
      checkOutput({tag, "_all"}, 32'(out_all), 32'(exp == 32));
      checkOutput({tag, "_none"}, 32'(out_none), 32'(exp == 0));
   endtask

   task automatic releaseResult(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] words [10];
      logic        modes [10];
      int          held, lat8, cyc, nAcc, nRes, lastHs;
      logic        acc, hs;
      logic [5:0]  seenCount;

      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
      in_valid8 = 1'b0; in_data8 = '0; in_mode8 = 1'b0; out_ready8 = 1'b0;
      tick();
      tick();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_count", 32'(out_count), 32'd0);
      checkOutput("rst_all", 32'(out_all), 32'd0);
      checkOutput("rst_none", 32'(out_none), 32'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] all-zero word, count zeros");
      applyStimulus(32'h0000_0000, 1'b0);
      waitResult("zeros", 32'h0000_0000, 1'b0);
      checkOutput("zeros_const", 32'(out_count), 32'd32);
      releaseResult("zeros");

      $display("[TB] F0F0F0F1 in both modes");
      applyStimulus(32'hF0F0_F0F1, 1'b1);
      waitResult("f0_ones", 32'hF0F0_F0F1, 1'b1);
      checkOutput("f0_ones_const", 32'(out_count), 32'd17);
      releaseResult("f0_ones");
      applyStimulus(32'hF0F0_F0F1, 1'b0);
      waitResult("f0_zeros", 32'hF0F0_F0F1, 1'b0);
      checkOutput("f0_zeros_const", 32'(out_count), 32'd15);

      $display("[TB] result held under backpressure");
      seenCount = out_count;
      for (held = 0; held < 5; held++) begin
         tick();
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_count", 32'(out_count), 32'(seenCount));
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      releaseResult("hold");

      $display("[TB] reset during RUN");
      applyStimulus(32'h1234_5678, 1'b1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_count", 32'(out_count), 32'd0);
      checkOutput("abort_all", 32'(out_all), 32'd0);
      checkOutput("abort_none", 32'(out_none), 32'd0);
      applyStimulus(32'hFFFF_FFFF, 1'b1);
      waitResult("after_abort", 32'hFFFF_FFFF, 1'b1);
      checkOutput("after_abort_const", 32'(out_count), 32'd32);
      releaseResult("after_abort");

      $display("[TB] single-chunk 8-bit instance");
      in_valid8 = 1'b1; in_data8 = 8'b1010_0110; in_mode8 = 1'b0;
      tick();
      in_valid8 = 1'b0;
      lat8 = 0;
      while (!out_valid8 && lat8 < 20) begin tick(); lat8++; end
      checkOutput("w8_latency", 32'(lat8), 32'd1);
      checkOutput("w8_count", 32'(out_count8), 32'(refCount(32'h0000_00A6, 1'b0, 8)));
      checkOutput("w8_count_const", 32'(out_count8), 32'd4);
      out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;
      checkOutput("w8_ready_back", 32'(in_ready8), 32'd1);
      in_valid8 = 1'b1; in_data8 = 8'hFF; in_mode8 = 1'b0;
      tick();
      in_valid8 = 1'b0;
      lat8 = 0;
      while (!out_valid8 && lat8 < 20) begin tick(); lat8++; end
      checkOutput("w8ff_count", 32'(out_count8), 32'd0);
      checkOutput("w8ff_none", 32'(out_none8), 32'd1);
      checkOutput("w8ff_all", 32'(out_all8), 32'd0);
      out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;

      $display("[TB] back-to-back random words");
      for (int i = 0; i < 10; i++) begin
         words[i] = $urandom;
         modes[i] = 1'($urandom);
      end
      in_valid = 1'b1; in_data = words[0]; in_mode = modes[0];
      out_ready = 1'b1;
      nAcc = 0; nRes = 0; lastHs = 0;
      for (cyc = 1; cyc <= 200 && nRes < 10; cyc++) begin
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         seenCount = out_count;
         tick();
         if (acc) begin
            nAcc++;
            if (nAcc < 10) begin
               in_data = words[nAcc];
               in_mode = modes[nAcc];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (hs) begin
            checkOutput("b2b_count", 32'(seenCount), 32'(refCount(words[nRes], modes[nRes], 32)));
            if (nRes > 0) begin
               checkOutput("b2b_interval", 32'(cyc - lastHs), 32'd6);
            end
            lastHs = cyc;
            nRes++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checkOutput("b2b_results", 32'(nRes), 32'd10);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
